// File: rtl/gray_pkg.sv
// Shared mode encodings and CF=8 luma coefficients for the RGB-to-grey pipeline,
// plus helpers that rescale the coefficients to other fraction widths.
package gray_pkg;

  typedef enum logic [1:0] {
    MODE_601  = 2'd0,
    MODE_709  = 2'd1,
    MODE_MEAN = 2'd2,
    MODE_PASS = 2'd3
  } gray_mode_e;

  localparam int unsigned COEF_601_R  = 77;
  localparam int unsigned COEF_601_G  = 150;
  localparam int unsigned COEF_601_B  = 29;
  localparam int unsigned COEF_709_R  = 54;
  localparam int unsigned COEF_709_G  = 183;
  localparam int unsigned COEF_709_B  = 19;
  localparam int unsigned COEF_MEAN_R = 85;
  localparam int unsigned COEF_MEAN_G = 86;
  localparam int unsigned COEF_MEAN_B = 85;

  // round(c * 2^cf / 256), ties upward; valid for cf up to about 22
  function automatic int unsigned coef_scale(input int unsigned c, input int unsigned cf);
    return (c * (32'd1 << cf) + 32'd128) / 32'd256;
  endfunction

  // Green absorbs the rounding error so the three coefficients sum to exactly 2^cf
  function automatic int unsigned coef_g(input int unsigned cr, input int unsigned cb,
                                         input int unsigned cf);
    return (32'd1 << cf) - coef_scale(cr, cf) - coef_scale(cb, cf);
  endfunction

endpackage

// File: rtl/gray_mac3.sv
// Stage 2 of the grey pipeline: three registered products and the adder tree that
// feeds the rounding/saturation stage.
module gray_mac3 #(
  parameter int unsigned DW = 8,
  parameter int unsigned CF = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic [DW-1:0]     i_r,
  input  logic [DW-1:0]     i_g,
  input  logic [DW-1:0]     i_b,
  input  logic [CF:0]       i_kr,
  input  logic [CF:0]       i_kg,
  input  logic [CF:0]       i_kb,
  output logic [DW+CF+1:0]  o_sum
);

  localparam int unsigned PW = DW + CF;
  localparam int unsigned SW = DW + CF + 2;

  logic [PW-1:0] w_pr, w_pg, w_pb;
  logic [PW-1:0] r_pr, r_pg, r_pb;

  // Coefficients never exceed 2^CF, so each product fits in DW+CF bits
  always_comb begin
    w_pr = PW'(i_r) * PW'(i_kr);
    w_pg = PW'(i_g) * PW'(i_kg);
    w_pb = PW'(i_b) * PW'(i_kb);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pr <= '0;
      r_pg <= '0;
      r_pb <= '0;
    end else if (i_en) begin
      r_pr <= w_pr;
      r_pg <= w_pg;
      r_pb <= w_pb;
    end
  end

  assign o_sum = SW'(r_pr) + SW'(r_pg) + SW'(r_pb);

endmodule

// File: rtl/gray_convert_pipe.sv
// Three-stage RGB-to-grey converter with valid/ready flow control and sof/eol sideband.
// Define GRAY_ROUND_EN to round half up instead of truncating the weighted sum.
module gray_convert_pipe
  import gray_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned CF = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] r_data,
  input  logic [DW-1:0] g_data,
  input  logic [DW-1:0] b_data,
  input  logic [1:0]    mode,
  input  logic          in_sof,
  input  logic          in_eol,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] gray_data,
  output logic          out_sof,
  output logic          out_eol
);

  localparam int unsigned CW = CF + 1;
  localparam int unsigned SW = DW + CF + 2;

  localparam logic [CW-1:0] K601_R  = CW'(coef_scale(COEF_601_R, CF));
  localparam logic [CW-1:0] K601_G  = CW'(coef_g(COEF_601_R, COEF_601_B, CF));
  localparam logic [CW-1:0] K601_B  = CW'(coef_scale(COEF_601_B, CF));
  localparam logic [CW-1:0] K709_R  = CW'(coef_scale(COEF_709_R, CF));
  localparam logic [CW-1:0] K709_G  = CW'(coef_g(COEF_709_R, COEF_709_B, CF));
  localparam logic [CW-1:0] K709_B  = CW'(coef_scale(COEF_709_B, CF));
  localparam logic [CW-1:0] KMEAN_R = CW'(coef_scale(COEF_MEAN_R, CF));
  localparam logic [CW-1:0] KMEAN_G = CW'(coef_g(COEF_MEAN_R, COEF_MEAN_B, CF));
  localparam logic [CW-1:0] KMEAN_B = CW'(coef_scale(COEF_MEAN_B, CF));
  localparam logic [CW-1:0] KPASS_G = {1'b1, {CF{1'b0}}};

`ifdef GRAY_ROUND_EN
  localparam logic [SW-1:0] RND = SW'(1) << (CF - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif
  localparam logic [SW-1:0] MAXV = {{(SW-DW){1'b0}}, {DW{1'b1}}};

  logic            w_en;
  logic            r_s1_valid, r_s1_sof, r_s1_eol;
  logic [DW-1:0]   r_s1_r, r_s1_g, r_s1_b;
  gray_mode_e      r_s1_mode;
  logic [CW-1:0]   w_kr, w_kg, w_kb;
  logic            r_s2_valid, r_s2_sof, r_s2_eol;
  logic [SW-1:0]   w_sum, w_rounded, w_shift;
  logic [DW-1:0]   w_gray;
  logic            r_out_valid, r_out_sof, r_out_eol;
  logic [DW-1:0]   r_gray;

  // Whole pipeline advances together; it only stalls when the output is held
  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_sof   <= 1'b0;
      r_s1_eol   <= 1'b0;
      r_s1_r     <= '0;
      r_s1_g     <= '0;
      r_s1_b     <= '0;
      r_s1_mode  <= MODE_601;
    end else if (w_en) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_sof  <= in_sof;
        r_s1_eol  <= in_eol;
        r_s1_r    <= r_data;
        r_s1_g    <= g_data;
        r_s1_b    <= b_data;
        r_s1_mode <= gray_mode_e'(mode);
      end
    end
  end

  // Passthrough reuses the MAC with weights (0, 2^CF, 0), so it yields g exactly
  always_comb begin
    w_kr = K601_R;
    w_kg = K601_G;
    w_kb = K601_B;
    unique case (r_s1_mode)
      MODE_601:  begin w_kr = K601_R;  w_kg = K601_G;  w_kb = K601_B;  end
      MODE_709:  begin w_kr = K709_R;  w_kg = K709_G;  w_kb = K709_B;  end
      MODE_MEAN: begin w_kr = KMEAN_R; w_kg = KMEAN_G; w_kb = KMEAN_B; end
      MODE_PASS: begin w_kr = '0;      w_kg = KPASS_G; w_kb = '0;      end
    endcase
  end

  gray_mac3 #(
    .DW (DW),
    .CF (CF)
  ) u_mac3 (
    .i_clk (clk),
    .i_rst (rst),
    .i_en  (w_en && r_s1_valid),
    .i_r   (r_s1_r),
    .i_g   (r_s1_g),
    .i_b   (r_s1_b),
    .i_kr  (w_kr),
    .i_kg  (w_kg),
    .i_kb  (w_kb),
    .o_sum (w_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_sof   <= 1'b0;
      r_s2_eol   <= 1'b0;
    end else if (w_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sof <= r_s1_sof;
        r_s2_eol <= r_s1_eol;
      end
    end
  end

  always_comb begin
    w_rounded = w_sum + RND;
    w_shift   = w_rounded >> CF;
    w_gray    = (w_shift > MAXV) ? MAXV[DW-1:0] : w_shift[DW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sof   <= 1'b0;
      r_out_eol   <= 1'b0;
      r_gray      <= '0;
    end else if (w_en) begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_sof <= r_s2_sof;
        r_out_eol <= r_s2_eol;
        r_gray    <= w_gray;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_sof   = r_out_sof;
  assign out_eol   = r_out_eol;
  assign gray_data = r_gray;

endmodule

// File: tb/tb_gray_convert_pipe.sv
// Scoreboard bench for gray_convert_pipe (DW=8, CF=8); honours GRAY_ROUND_EN.
module tb_gray_convert_pipe;

  localparam int DW = 8;
  localparam int CF = 8;
`ifdef GRAY_ROUND_EN
  localparam int RND = 128;
  localparam logic [7:0] EXP_RED = 8'd77;
  localparam logic [7:0] EXP_BLUE709 = 8'd19;
`else
  localparam int RND = 0;
  localparam logic [7:0] EXP_RED = 8'd76;
  localparam logic [7:0] EXP_BLUE709 = 8'd18;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [7:0] r_data, g_data, b_data;
  logic [1:0] mode;
  logic       in_sof, in_eol;
  logic       out_valid, out_ready;
  logic [7:0] gray_data;
  logic       out_sof, out_eol;

  typedef struct packed {
    logic [7:0] gray;
    logic       sof;
    logic       eol;
  } exp_t;

  exp_t       q[$];
  logic [7:0] cur_exp;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  gray_convert_pipe #(
    .DW (DW),
    .CF (CF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_data    (r_data),
    .g_data    (g_data),
    .b_data    (b_data),
    .mode      (mode),
    .in_sof    (in_sof),
    .in_eol    (in_eol),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .gray_data (gray_data),
    .out_sof   (out_sof),
    .out_eol   (out_eol)
  );

  // Push side: an acceptance seen half a cycle before the edge queues its expectation
  initial forever begin
    @(negedge clk);
    if (rst) q.delete();
    else if (in_valid && in_ready) q.push_back({cur_exp, in_sof, in_eol});
  end

  // Monitor: every output transfer pops and compares
  initial forever begin
    exp_t e, got;
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      checks++;
      got = {gray_data, out_sof, out_eol};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got gray=%0d sof=%0d eol=%0d, want no output",
                 gray_data, out_sof, out_eol);
      end else begin
        e = q.pop_front();
        if (got !== e) begin
          errors++;
          $display("FAIL out_pixel: got gray=%0d sof=%0d eol=%0d want gray=%0d sof=%0d eol=%0d",
                   gray_data, out_sof, out_eol, e.gray, e.sof, e.eol);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Presents one pixel and returns just after the edge that accepted it
  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                      input logic [1:0] m, input logic s, input logic e,
                      input logic [7:0] x);
    int   n;
    logic acc;
    r_data = r; g_data = g; b_data = b; mode = m; in_sof = s; in_eol = e;
    cur_exp = x;
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = in_ready;
      n++;
      if (!acc) begin
        @(posedge clk);
        #1;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles want 1", n);
      in_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] model(input logic [7:0] r, input logic [7:0] g,
                                       input logic [7:0] b, input logic [1:0] m);
    int kr, kg, kb, acc;
    case (m)
      2'd0:    begin kr = 77; kg = 150; kb = 29; end
      2'd1:    begin kr = 54; kg = 183; kb = 19; end
      2'd2:    begin kr = 85; kg = 86;  kb = 85; end
      default: return g;
    endcase
    acc = (int'(r) * kr + int'(g) * kg + int'(b) * kb + RND) >> 8;
    if (acc > 255) acc = 255;
    return 8'(acc);
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int   sent, cyc, n;
    logic acc_last;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    r_data = '0; g_data = '0; b_data = '0; mode = '0; in_sof = 1'b0; in_eol = 1'b0;
    cur_exp = '0;
    idle(2);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_gray", 32'(gray_data), 0);
    chk("rst_sof", 32'(out_sof), 0);
    chk("rst_eol", 32'(out_eol), 0);
    rst = 1'b0;
    idle(1);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Latency: white in BT.601, out_valid on the third edge counting acceptance
    send(8'd255, 8'd255, 8'd255, 2'd0, 1'b1, 1'b0, 8'd255);
    in_valid = 1'b0;
    chk("lat_edge1", 32'(out_valid), 0);
    idle(1);
    chk("lat_edge2", 32'(out_valid), 0);
    idle(1);
    chk("lat_edge3", 32'(out_valid), 1);
    idle(3);

    send(8'd255, 8'd0, 8'd0, 2'd0, 1'b0, 1'b0, EXP_RED);
    send(8'd0, 8'd255, 8'd0, 2'd1, 1'b0, 1'b0, 8'd182);
    send(8'd30, 8'd60, 8'd90, 2'd2, 1'b0, 1'b0, 8'd60);
    send(8'd10, 8'd200, 8'd30, 2'd3, 1'b0, 1'b1, 8'd200);
    in_valid = 1'b0;
    idle(5);

    // Backpressure: three pixels enter, then the output is held for five cycles
    out_ready = 1'b0;
    send(8'd100, 8'd100, 8'd100, 2'd0, 1'b1, 1'b0, 8'd100);
    send(8'd0, 8'd0, 8'd255, 2'd1, 1'b0, 1'b0, EXP_BLUE709);
    send(8'd40, 8'd80, 8'd120, 2'd2, 1'b0, 1'b1, 8'd80);
    in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stall_in_ready", 32'(in_ready), 0);
      chk("stall_out_valid", 32'(out_valid), 1);
      chk("stall_gray", 32'(gray_data), 100);
      chk("stall_sof", 32'(out_sof), 1);
      idle(1);
    end
    out_ready = 1'b1;
    chk("drain_v1", 32'(out_valid), 1);
    idle(1);
    chk("drain_v2", 32'(out_valid), 1);
    idle(1);
    chk("drain_v3", 32'(out_valid), 1);
    idle(1);
    chk("drain_done", 32'(out_valid), 0);
    idle(2);

    // Reset with two pixels in flight
    send(8'd1, 8'd2, 8'd3, 2'd3, 1'b1, 1'b0, 8'd2);
    send(8'd4, 8'd5, 8'd6, 2'd3, 1'b0, 1'b1, 8'd5);
    in_valid = 1'b0;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    for (int i = 0; i < 6; i++) begin
      idle(1);
      chk("midrst_no_output", 32'(out_valid), 0);
    end

    // Random handshake stream against the reference model
    sent = 0;
    cyc = 0;
    acc_last = 1'b0;
    while (sent < 1000 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || acc_last) begin
        in_valid = ($urandom_range(0, 2) != 0);
        r_data = 8'($urandom_range(0, 255));
        g_data = 8'($urandom_range(0, 255));
        b_data = 8'($urandom_range(0, 255));
        mode   = 2'($urandom_range(0, 3));
        in_sof = 1'($urandom_range(0, 1));
        in_eol = 1'($urandom_range(0, 1));
        cur_exp = model(r_data, g_data, b_data, mode);
      end
      @(negedge clk);
      acc_last = in_valid && in_ready;
      if (acc_last) sent++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("rand_sent", 32'(sent), 1000);
    n = 0;
    while (q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    idle(2);
    chk("queue_empty", 32'(q.size()), 0);
    chk("final_out_valid", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
